dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_lane_dec.sv | 38 +++
 rtl/dm_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states and
// the default byte-address width.
package dm_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 12;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_lane_dec.sv
// Byte-lane decode: turns access size, low address bits and write data into
// byte enables, lane-positioned write data and a misalignment flag.
module dm_lane_dec
  import dm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = 4'b0000;
    data_o       = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        // Byte data always travels on bits 7:0; only the enable selects the lane.
        be_o   = 4'b0001 << addr_lo_i;
        data_o = {24'h0, wdata_i[7:0]};
      end
      SZ_HALF: begin
        misaligned_o = addr_lo_i[0];
        data_o       = addr_lo_i[1] ? {wdata_i[15:0], 16'h0} : {16'h0, wdata_i[15:0]};
        if (!addr_lo_i[0]) be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        misaligned_o = |addr_lo_i;
        data_o       = wdata_i;
        if (addr_lo_i == 2'b00) be_o = 4'b1111;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each grant runs IDLE -> ACCESS -> RESP; all outputs are registered.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [1:0]        size0,
  input  logic              sign0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        size1,
  input  logic              sign1,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [31:0]       rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-3:0] dm_A,
  output logic [31:0]       dm_D,
  output logic [3:0]        dm_Membe,
  output logic              dm_Sign,
  output logic              dm_Memwrite,
  output logic              dm_Memread,
  input  logic [31:0]       dm_out
);

  dm_state_e         state_q, state_d;
  logic              gnt_q, gnt_d, last_q, last_d, we_q, we_d, mis_q, mis_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
  logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-3:0] dm_a_q, dm_a_d;
  logic [31:0]       dm_d_q, dm_d_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic              dm_sign_q, dm_sign_d, dm_wr_q, dm_wr_d, dm_rd_q, dm_rd_d;

  logic              sel, sel_we, sel_sign;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [31:0]       sel_wdata, dec_data, rd_val;
  logic [3:0]        dec_be;
  logic              dec_mis;

  // On a tie the requester that did not win last time is chosen.
  assign sel       = (req0 & req1) ? ~last_q : req1;
  assign sel_we    = sel ? we1 : we0;
  assign sel_sign  = sel ? sign1 : sign0;
  assign sel_addr  = sel ? addr1 : addr0;
  assign sel_size  = sel ? size1 : size0;
  assign sel_wdata = sel ? wdata1 : wdata0;
  assign rd_val    = (we_q | mis_q) ? 32'h0 : dm_out;

  dm_lane_dec u_lane_dec (
    .size_i      (sel_size),
    .addr_lo_i   (sel_addr[1:0]),
    .wdata_i     (sel_wdata),
    .be_o        (dec_be),
    .data_o      (dec_data),
    .misaligned_o(dec_mis)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    mis_d     = mis_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    dm_a_d    = dm_a_q;
    dm_d_d    = dm_d_q;
    dm_sign_d = dm_sign_q;
    dm_be_d   = 4'b0000;
    dm_wr_d   = 1'b0;
    dm_rd_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d   = StAccess;
          gnt_d     = sel;
          last_d    = sel;
          we_d      = sel_we;
          mis_d     = dec_mis;
          dm_a_d    = sel_addr[ADDR_W-1:2];
          dm_d_d    = dec_data;
          dm_sign_d = sel_sign;
          if (!dec_mis) begin
            dm_be_d = dec_be;
            dm_wr_d = sel_we;
            dm_rd_d = ~sel_we;
          end
        end
      end
      StAccess: begin
        state_d = StResp;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        err0_d  = ~gnt_q & mis_q;
        err1_d  = gnt_q & mis_q;
        if (gnt_q) rdata1_d = rd_val;
        else       rdata0_d = rd_val;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      dm_a_q    <= '0;
      dm_d_q    <= 32'h0;
      dm_be_q   <= 4'b0000;
      dm_sign_q <= 1'b0;
      dm_wr_q   <= 1'b0;
      dm_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      dm_a_q    <= dm_a_d;
      dm_d_q    <= dm_d_d;
      dm_be_q   <= dm_be_d;
      dm_sign_q <= dm_sign_d;
      dm_wr_q   <= dm_wr_d;
      dm_rd_q   <= dm_rd_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign dm_A        = dm_a_q;
  assign dm_D        = dm_d_q;
  assign dm_Membe    = dm_be_q;
  assign dm_Sign     = dm_sign_q;
  assign dm_Memwrite = dm_wr_q;
  assign dm_Memread  = dm_rd_q;

endmodule
